ss_scan_driver: RTL

- Time-multiplexed scan driver for the 8-digit seven-segment display on the Nexys-A7.
- Sits directly downstream of the dual benchmark timer and consumes its eight 4-bit BCD digits (timer 1 on digits 7..4, timer 2 on digits 3..0).
- Snapshots all digits once per frame so a display never tears mid-scan.
- Applies per-digit enable, per-digit decimal point and a ghost-suppression blanking gap, then drives the active-low anodes and cathodes.

---
 rtl/ss_scan_driver.sv | 116 +++++++++++
 1 files changed

// File: rtl/ss_scan_driver.sv
// Time-multiplexed driver for an 8-digit seven-segment display.
// The digits are snapshotted once per frame, and a blanking gap at the start of each slot suppresses ghosting.
module ss_scan_driver #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        CLK100MHZ,
  input  logic        btn_reset,
  input  logic [31:0] digits,
  input  logic [7:0]  dp,
  input  logic [7:0]  digit_ena,
  output logic [7:0]  SS_EN,
  output logic [7:0]  SS,
  output logic        frame_done
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      snap_digits_q;
  logic [7:0]       snap_dp_q, snap_ena_q;
  logic [7:0]       ss_en_q, ss_en_d;
  logic [7:0]       ss_q, ss_d;
  logic             frame_done_q, frame_done_d;

  logic             slot_end, frame_end, in_blank, dark;
  logic [3:0]       snap_nib [8];
  logic [3:0]       cur_nib;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == 3'd7);

  for (genvar gi = 0; gi < 8; gi++) begin : g_nib
    assign snap_nib[gi] = snap_digits_q[4*gi +: 4];
  end
  assign cur_nib = snap_nib[idx_q];

  // With no blanking the compare would be constant-false, so it is not built at all.
  if (BLANK_CYCLES == 0) begin : g_noblank
    assign in_blank = 1'b0;
  end else begin : g_blank
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
    assign in_blank = (cnt_q < BLANK_LIM);
  end

  // Active-low {g,f,e,d,c,b,a}; 10..15 render as hex glyphs.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0:    seg7 = 7'h40;
      4'h1:    seg7 = 7'h79;
      4'h2:    seg7 = 7'h24;
      4'h3:    seg7 = 7'h30;
      4'h4:    seg7 = 7'h19;
      4'h5:    seg7 = 7'h12;
      4'h6:    seg7 = 7'h02;
      4'h7:    seg7 = 7'h78;
      4'h8:    seg7 = 7'h00;
      4'h9:    seg7 = 7'h10;
      4'hA:    seg7 = 7'h08;
      4'hB:    seg7 = 7'h03;
      4'hC:    seg7 = 7'h46;
      4'hD:    seg7 = 7'h21;
      4'hE:    seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    ss_en_d      = 8'hFF;
    ss_d         = 8'hFF;
    frame_done_d = frame_end;
    dark         = in_blank || !snap_ena_q[idx_q];
    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
    if (!dark) begin
      ss_en_d = ~(8'h01 << idx_q);
      ss_d    = {~snap_dp_q[idx_q], seg7(cur_nib)};
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (btn_reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      ss_en_q      <= 8'hFF;
      ss_q         <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      ss_en_q      <= ss_en_d;
      ss_q         <= ss_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Reloading during reset means the first frame shows the inputs from the last reset cycle.
  always_ff @(posedge CLK100MHZ) begin
    if (btn_reset || frame_end) begin
      snap_digits_q <= digits;
      snap_dp_q     <= dp;
      snap_ena_q    <= digit_ena;
    end
  end

  assign SS_EN      = ss_en_q;
  assign SS         = ss_q;
  assign frame_done = frame_done_q;

endmodule
